alu_arbiter: RTL and testbench

Shares one registered 8-bit ALU between `NREQ` requesters. Each requester issues an (A, B, CTR) operation through a valid/ready handshake. The block routes each result back to its originator, using the ALU's fixed 2-cycle latency and an internal tag pipeline. It sits between the requesting engines and the single ALU instance, and it owns the ALU's `A`, `B` and `CTR` inputs.

---
 rtl/alu_arb_pkg.sv | 27 ++
 rtl/alu_arb_pick.sv | 41 ++++
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared opcodes, ALU latency and the response-tag type for
// the ALU arbiter. ALU_ARB_RR_EN (see alu_arbiter) selects round robin.
package alu_arb_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_SRL = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1101;
  localparam logic [3:0] OP_ROR = 4'b1110;
  localparam logic [3:0] OP_ROL = 4'b1111;

  // Cycles from operand sample to result on the ALU O output.
  localparam int unsigned ALU_LAT = 2;

  // Wide enough for the largest supported requester count (4).
  localparam int unsigned TAG_IDW = 2;

  typedef struct packed {
    logic               v;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: combinational requester selection.
// Ports:
//   req_valid - request bits, one per requester
//   start     - first index searched when RR_EN is set (ignored otherwise)
//   gnt       - one-hot grant, zero when nothing is valid
//   gnt_id    - index of the granted requester (0 when no grant)
module alu_arb_pick #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDW   = 2,
  parameter bit          RR_EN = 1'b0
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  start,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  // Search from base upward, wrapping modulo NREQ; first valid wins.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    logic        found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    base   = RR_EN ? 32'(start) : 32'd0;
    idx    = 32'd0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = base + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (idx == i)) begin
          gnt[i] = 1'b1;
          gnt_id = IDW'(i);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 2-cycle registered 8-bit ALU between NREQ
// requesters and routes each result back to its issuer via a tag pipeline.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; without
// it the lowest valid index wins. Lock (burst) behaviour is the same in both.
// Ports:
//   ck, rst_n            - clock, async active-low reset
//   req_valid/req_lock   - per-requester request and burst-hold bits
//   req_a/req_b/req_ctr  - packed per-requester operands and opcode
//   req_ready            - combinational one-hot grant
//   rsp_valid/rsp_data   - result strobe to the issuer, result byte
//   alu_a/alu_b/alu_ctr  - combinational operands to the ALU
//   alu_o                - ALU result
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  input  logic [NREQ*4-1:0] req_ctr,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_data,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_ctr,
  input  logic [7:0]        alu_o
);

  logic            lock_active;
  logic [IDW-1:0]  lock_owner;
  logic            lock_hit;
  logic            issue;
  logic            issue_lock;
  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_id;
  logic [IDW-1:0]  start_id;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  tag_t            pipe [ALU_LAT];

`ifdef ALU_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
  logic [IDW-1:0] rr_ptr;

  // Pointer moves past every issuer, locked issues included.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  assign start_id = rr_ptr;
`else
  localparam bit RR_EN = 1'b0;
  assign start_id = '0;
`endif

  alu_arb_pick #(
    .NREQ  (NREQ),
    .IDW   (IDW),
    .RR_EN (RR_EN)
  ) u_pick (
    .req_valid (req_valid),
    .start     (start_id),
    .gnt       (pick_gnt),
    .gnt_id    (pick_id)
  );

  // A live lock owner overrides the picker; a dropped owner falls through.
  always_comb begin
    lock_hit = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (lock_active && (lock_owner == IDW'(i)) && req_valid[i]) lock_hit = 1'b1;
    end
    gnt    = pick_gnt;
    gnt_id = pick_id;
    if (lock_hit) begin
      gnt = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (lock_owner == IDW'(i)) gnt[i] = 1'b1;
      end
      gnt_id = lock_owner;
    end
  end

  assign issue      = |gnt;
  assign issue_lock = |(gnt & req_lock);
  assign req_ready  = gnt;

  // Operand mux; zeros (ADD of 0,0) when idle.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ctr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        alu_a   = req_a[8*i +: 8];
        alu_b   = req_b[8*i +: 8];
        alu_ctr = req_ctr[4*i +: 4];
      end
    end
  end

  // Lock state; any idle cycle releases the lock.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      lock_active <= 1'b0;
      lock_owner  <= '0;
    end else if (issue) begin
      lock_active <= issue_lock;
      lock_owner  <= gnt_id;
    end else begin
      lock_active <= 1'b0;
    end
  end

  // Tag pipeline tracks each issue alongside the ALU's internal stages.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ALU_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{v: issue, id: TAG_IDW'(gnt_id)};
      for (int unsigned i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Decode the oldest tag into a one-hot response strobe.
  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pipe[ALU_LAT-1].v && (pipe[ALU_LAT-1].id == TAG_IDW'(i))) rsp_valid[i] = 1'b1;
    end
  end

  assign rsp_data = alu_o;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven check of alu_arbiter (NREQ=2) with a
// behavioural 2-stage ALU attached; plus reset and reset-mid-flight sequences.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        ck;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_lock;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_ctr;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_ctr;
  logic [7:0]  alu_o;
  logic [7:0]  alu_st;

  int n_vec = 0;
  int n_bad = 0;

  alu_arbiter #(.NREQ(2), .IDW(2)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ctr   (req_ctr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctr   (alu_ctr),
    .alu_o     (alu_o)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    case (c)
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a - b;
      OP_AND:  alu_f = a & b;
      OP_OR:   alu_f = a | b;
      OP_XOR:  alu_f = a ^ b;
      OP_NOT:  alu_f = ~a;
      OP_SRL:  alu_f = a >> 1;
      OP_SLL:  alu_f = a << 1;
      OP_ROR:  alu_f = {a[0], a[7:1]};
      OP_ROL:  alu_f = {a[6:0], a[7]};
      default: alu_f = 8'h00;
    endcase
  endfunction

  // Unreset two-stage ALU: samples at E, O updates at E+1.
  always_ff @(posedge ck) begin
    alu_st <= alu_f(alu_a, alu_b, alu_ctr);
    alu_o  <= alu_st;
  end

  typedef struct {
    logic [1:0] v;
    logic [1:0] l;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [3:0] c0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic [3:0] c1;
    logic [1:0] rdy;
    logic [1:0] rv;
    logic [7:0] rd;
  } vec_t;

  vec_t vq[$];

  function automatic void row(input logic [1:0] v, input logic [1:0] l,
                              input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] c0,
                              input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] c1,
                              input logic [1:0] rdy, input logic [1:0] rv, input logic [7:0] rd);
    vec_t e;
    e = '{v, l, a0, b0, c0, a1, b1, c1, rdy, rv, rd};
    vq.push_back(e);
  endfunction

  function automatic void idle(input logic [1:0] rv, input logic [7:0] rd);
    row(2'b00, 2'b00, 8'h00, 8'h00, OP_ADD, 8'h00, 8'h00, OP_ADD, 2'b00, rv, rd);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l,
                       input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] c0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] c1);
    req_valid = v;
    req_lock  = l;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_ctr   = {c1, c0};
  endtask

  initial begin
    vec_t       e;
    logic [7:0] ea;
    logic [3:0] ec;

    rst_n = 1'b0;
    drive(2'b00, 2'b00, 8'h00, 8'h00, OP_ADD, 8'h00, 8'h00, OP_ADD);

    // Reset state: no responses; grant depends only on inputs.
    @(negedge ck); #1;
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rdy idle", 32'(req_ready), 32'h0);
    chk("reset alu_ctr idle", 32'(alu_ctr), 32'h0);
    drive(2'b10, 2'b00, 8'h00, 8'h00, OP_ADD, 8'h12, 8'h00, OP_OR);
    #1;
    chk("reset rdy req1", 32'(req_ready), 32'h2);
    chk("reset alu_a req1", 32'(alu_a), 32'h12);
    drive(2'b00, 2'b00, 8'h00, 8'h00, OP_ADD, 8'h00, 8'h00, OP_ADD);
    @(negedge ck);
    rst_n = 1'b1;

    // Single ops, with mod-256 wrap both ways
    row(2'b01, 2'b00, 8'h7F, 8'h01, OP_ADD, 8'h00, 8'h00, OP_ADD, 2'b01, 2'b00, 8'h00);
    row(2'b10, 2'b00, 8'h00, 8'h00, OP_ADD, 8'h00, 8'h01, OP_SUB, 2'b10, 2'b00, 8'h00);
    idle(2'b01, 8'h80);
    idle(2'b10, 8'hFF);
    idle(2'b00, 8'h00);

`ifdef ALU_ARB_RR_EN
    // Contention, round robin: alternating grants and responses
    row(2'b11, 2'b00, 8'hF0, 8'h3C, OP_XOR, 8'h10, 8'h20, OP_SUB, 2'b01, 2'b00, 8'h00);
    row(2'b11, 2'b00, 8'hF0, 8'h3C, OP_XOR, 8'h10, 8'h20, OP_SUB, 2'b10, 2'b00, 8'h00);
    row(2'b11, 2'b00, 8'hF0, 8'h3C, OP_AND, 8'h0F, 8'h30, OP_OR,  2'b01, 2'b01, 8'hCC);
    row(2'b11, 2'b00, 8'hF0, 8'h3C, OP_AND, 8'h0F, 8'h30, OP_OR,  2'b10, 2'b10, 8'hF0);
    row(2'b11, 2'b00, 8'h7F, 8'h7F, OP_ADD, 8'hA5, 8'h00, OP_NOT, 2'b01, 2'b01, 8'h30);
    row(2'b11, 2'b00, 8'h7F, 8'h7F, OP_ADD, 8'hA5, 8'h00, OP_NOT, 2'b10, 2'b10, 8'h3F);
    idle(2'b01, 8'hFE);
    idle(2'b10, 8'h5A);
    idle(2'b00, 8'h00);
`else
    // Contention, fixed priority: requester 1 starved
    row(2'b11, 2'b00, 8'hF0, 8'h3C, OP_XOR, 8'h10, 8'h20, OP_SUB, 2'b01, 2'b00, 8'h00);
    row(2'b11, 2'b00, 8'hF0, 8'h3C, OP_AND, 8'h10, 8'h20, OP_SUB, 2'b01, 2'b00, 8'h00);
    row(2'b11, 2'b00, 8'hF0, 8'h3C, OP_OR,  8'h10, 8'h20, OP_SUB, 2'b01, 2'b01, 8'hCC);
    row(2'b11, 2'b00, 8'hF0, 8'h3C, OP_ADD, 8'h10, 8'h20, OP_SUB, 2'b01, 2'b01, 8'h30);
    idle(2'b01, 8'hFC);
    idle(2'b01, 8'h2C);
    idle(2'b00, 8'h00);
`endif

    // Lock: requester 1 keeps the grant for 3 cycles over requester 0
    row(2'b10, 2'b10, 8'hFF, 8'h0F, OP_AND, 8'h01, 8'h02, OP_ADD, 2'b10, 2'b00, 8'h00);
    row(2'b11, 2'b10, 8'hFF, 8'h0F, OP_AND, 8'h03, 8'h04, OP_ADD, 2'b10, 2'b00, 8'h00);
    row(2'b11, 2'b00, 8'hFF, 8'h0F, OP_AND, 8'h09, 8'h01, OP_SUB, 2'b10, 2'b10, 8'h03);
    row(2'b11, 2'b00, 8'hFF, 8'h0F, OP_AND, 8'h77, 8'h77, OP_ADD, 2'b01, 2'b10, 8'h07);
    idle(2'b10, 8'h08);
    // Lock owner drops valid: normal arbitration in the same cycle
    row(2'b10, 2'b10, 8'h00, 8'h00, OP_ADD, 8'h50, 8'h05, OP_OR,  2'b10, 2'b01, 8'h0F);
    row(2'b01, 2'b00, 8'h55, 8'hFF, OP_XOR, 8'h00, 8'h00, OP_ADD, 2'b01, 2'b00, 8'h00);
    idle(2'b10, 8'h55);
    idle(2'b01, 8'hAA);
    idle(2'b00, 8'h00);

    // Opcode sweep on 0xA5, alternating issuers
    row(2'b01, 2'b00, 8'hA5, 8'h3C, OP_SRL,  8'h00, 8'h00, OP_ADD,  2'b01, 2'b00, 8'h00);
    row(2'b10, 2'b00, 8'h00, 8'h00, OP_ADD,  8'hA5, 8'h3C, OP_SLL,  2'b10, 2'b00, 8'h00);
    row(2'b01, 2'b00, 8'hA5, 8'h3C, OP_ROR,  8'h00, 8'h00, OP_ADD,  2'b01, 2'b01, 8'h52);
    row(2'b10, 2'b00, 8'h00, 8'h00, OP_ADD,  8'hA5, 8'h3C, OP_ROL,  2'b10, 2'b10, 8'h4A);
    row(2'b01, 2'b00, 8'hA5, 8'h3C, OP_NOT,  8'h00, 8'h00, OP_ADD,  2'b01, 2'b01, 8'hD2);
    row(2'b10, 2'b00, 8'h00, 8'h00, OP_ADD,  8'hA5, 8'h3C, 4'b0101, 2'b10, 2'b10, 8'h4B);
    row(2'b01, 2'b00, 8'hFF, 8'h02, OP_ADD,  8'h00, 8'h00, OP_ADD,  2'b01, 2'b01, 8'h5A);
    idle(2'b10, 8'h00);
    idle(2'b01, 8'h01);
    idle(2'b00, 8'h00);

    foreach (vq[i]) begin
      e = vq[i];
      @(negedge ck);
      drive(e.v, e.l, e.a0, e.b0, e.c0, e.a1, e.b1, e.c1);
      #1;
      ea = (e.rdy == 2'b01) ? e.a0 : (e.rdy == 2'b10) ? e.a1 : 8'h00;
      ec = (e.rdy == 2'b01) ? e.c0 : (e.rdy == 2'b10) ? e.c1 : 4'h0;
      chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(e.rdy));
      chk($sformatf("row%0d alu_a", i), 32'(alu_a), 32'(ea));
      chk($sformatf("row%0d alu_ctr", i), 32'(alu_ctr), 32'(ec));
      chk($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(e.rv));
      if (e.rv != 2'b00) chk($sformatf("row%0d rsp_data", i), 32'(rsp_data), 32'(e.rd));
    end

    // Reset one cycle after an issue: that operation never responds
    @(negedge ck);
    drive(2'b01, 2'b00, 8'h11, 8'h22, OP_ADD, 8'h00, 8'h00, OP_ADD);
    #1;
    chk("rstmid issue rdy", 32'(req_ready), 32'h1);
    @(negedge ck);
    drive(2'b00, 2'b00, 8'h00, 8'h00, OP_ADD, 8'h00, 8'h00, OP_ADD);
    rst_n = 1'b0;
    #1;
    chk("rstmid rsp in reset", 32'(rsp_valid), 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge ck); #1;
      chk($sformatf("rstmid hold%0d rsp", c), 32'(rsp_valid), 32'h0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge ck); #1;
      chk($sformatf("rstmid post%0d rsp", c), 32'(rsp_valid), 32'h0);
    end

    // Fresh issue after reset returns normally
    @(negedge ck);
    drive(2'b10, 2'b00, 8'h00, 8'h00, OP_ADD, 8'h40, 8'h02, OP_ADD);
    #1;
    chk("fresh rdy", 32'(req_ready), 32'h2);
    @(negedge ck);
    drive(2'b00, 2'b00, 8'h00, 8'h00, OP_ADD, 8'h00, 8'h00, OP_ADD);
    #1;
    chk("fresh rsp early", 32'(rsp_valid), 32'h0);
    @(negedge ck); #1;
    chk("fresh rsp_valid", 32'(rsp_valid), 32'h2);
    chk("fresh rsp_data", 32'(rsp_data), 32'h42);
    @(negedge ck); #1;
    chk("fresh rsp after", 32'(rsp_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
